data_memory_arbiter: RTL and testbench

Two-requester arbiter sharing the single-port data memory between the general-purpose processor (GPP) and the communications processor (CP) inside the computer node. The CP has priority so received network data is never stalled for long, and a starvation counter guarantees the GPP a grant after a bounded wait. Each granted access drives the memory port for one cycle. Read data is registered and returned one cycle later with a valid strobe.

---
 rtl/data_memory_arbiter.sv | 101 ++++++++++
 tb/tb_data_memory_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
//   Shares the single-port data memory between the GPP and the CP.
//   The CP has priority. A starvation counter forces a GPP win after the
//   GPP has been denied MAX_WAIT consecutive cycles. Grants are
//   combinational, and each grant owns the memory port for one cycle.
//   Read data is registered and returned one cycle later with an rvalid pulse.
// Ports
//   clk, rst             clock (rising edge), async active-low reset
//   gpp_* / cp_*         request fields in; gnt, rvalid and rdata out
//   mem_we/addr/wdata    memory port; addr/wdata hold the last grant when idle
//   mem_rdata            combinational read data from mem_addr
//   conflict_cnt         saturating count of cycles where both requested
module data_memory_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gpp_req,
  input  logic              gpp_we,
  input  logic [ADDR_W-1:0] gpp_addr,
  input  logic [DATA_W-1:0] gpp_wdata,
  output logic              gpp_gnt,
  output logic              gpp_rvalid,
  output logic [DATA_W-1:0] gpp_rdata,
  input  logic              cp_req,
  input  logic              cp_we,
  input  logic [ADDR_W-1:0] cp_addr,
  input  logic [DATA_W-1:0] cp_wdata,
  output logic              cp_gnt,
  output logic              cp_rvalid,
  output logic [DATA_W-1:0] cp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       conflict_cnt
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mreq_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  mreq_t             gpp_r, cp_r, sel_r;
  logic              gpp_win;
  logic [7:0]        wait_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_wdata;

  assign gpp_r = '{we: gpp_we, addr: gpp_addr, wdata: gpp_wdata};
  assign cp_r  = '{we: cp_we,  addr: cp_addr,  wdata: cp_wdata};

  // The GPP wins when it is alone, or when it has starved for MAX_WAIT cycles.
  assign gpp_win = gpp_req && (!cp_req || (wait_cnt == MAX_WAIT_C));
  // Grants are gated by reset so no access leaks out while rst=0.
  assign gpp_gnt = rst & gpp_win;
  assign cp_gnt  = rst & cp_req & ~gpp_win;

  always_comb begin
    sel_r = '{we: 1'b0, addr: last_addr, wdata: last_wdata};
    if (gpp_gnt)     sel_r = gpp_r;
    else if (cp_gnt) sel_r = cp_r;
  end

  assign mem_we    = sel_r.we;
  assign mem_addr  = sel_r.addr;
  assign mem_wdata = sel_r.wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_addr    <= '0;
      last_wdata   <= '0;
      wait_cnt     <= '0;
      conflict_cnt <= '0;
      gpp_rvalid   <= 1'b0;
      cp_rvalid    <= 1'b0;
      gpp_rdata    <= '0;
      cp_rdata     <= '0;
    end else begin
      if (gpp_gnt || cp_gnt) begin
        last_addr  <= sel_r.addr;
        last_wdata <= sel_r.wdata;
      end
      // wait_cnt cannot pass MAX_WAIT: reaching it forces a GPP grant, which clears it.
      if (!gpp_req || gpp_gnt)         wait_cnt <= '0;
      else if (wait_cnt != MAX_WAIT_C) wait_cnt <= wait_cnt + 8'd1;
      if (gpp_req && cp_req && (conflict_cnt != 16'hFFFF))
        conflict_cnt <= conflict_cnt + 16'd1;
      gpp_rvalid <= gpp_gnt & ~gpp_we;
      cp_rvalid  <= cp_gnt & ~cp_we;
      if (gpp_gnt && !gpp_we) gpp_rdata <= mem_rdata;
      if (cp_gnt && !cp_we)   cp_rdata  <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        gpp_req, gpp_we, cp_req, cp_we;
  logic [15:0] gpp_addr, gpp_wdata, cp_addr, cp_wdata;
  logic        gpp_gnt, gpp_rvalid, cp_gnt, cp_rvalid, mem_we;
  logic [15:0] gpp_rdata, cp_rdata, mem_addr, mem_wdata, mem_rdata, conflict_cnt;
  logic [15:0] mem [0:255];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_memory_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .gpp_req(gpp_req), .gpp_we(gpp_we), .gpp_addr(gpp_addr), .gpp_wdata(gpp_wdata),
    .gpp_gnt(gpp_gnt), .gpp_rvalid(gpp_rvalid), .gpp_rdata(gpp_rdata),
    .cp_req(cp_req), .cp_we(cp_we), .cp_addr(cp_addr), .cp_wdata(cp_wdata),
    .cp_gnt(cp_gnt), .cp_rvalid(cp_rvalid), .cp_rdata(cp_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  // Simple memory model: combinational read, write on rising edge.
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  task automatic idle_reqs();
    gpp_req = 0; gpp_we = 0; gpp_addr = 0; gpp_wdata = 0;
    cp_req = 0; cp_we = 0; cp_addr = 0; cp_wdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle_reqs(); rst = 0;
    @(negedge clk); rst = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 0;
    gpp_req = 1; gpp_we = 1; gpp_addr = 16'h1234; gpp_wdata = 16'hAAAA;
    cp_req = 1; cp_we = 1; cp_addr = 16'h5678; cp_wdata = 16'h5555;
    @(posedge clk); @(negedge clk);
    n_cmp++; if ({gpp_gnt, cp_gnt} !== 2'b00) begin n_bad++; $display("FAIL reset_gnt got %b want 00", {gpp_gnt, cp_gnt}); end
    n_cmp++; if (mem_we !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin n_bad++;
      $display("FAIL reset_mem got we=%b addr=%h wdata=%h want 0/0000/0000", mem_we, mem_addr, mem_wdata); end
    n_cmp++; if ({gpp_rvalid, cp_rvalid} !== 2'b00 || gpp_rdata !== 16'h0 || cp_rdata !== 16'h0) begin n_bad++;
      $display("FAIL reset_rd got rv=%b gd=%h cd=%h want 00/0000/0000", {gpp_rvalid, cp_rvalid}, gpp_rdata, cp_rdata); end
    n_cmp++; if (conflict_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_conflict got %h want 0000", conflict_cnt); end
    rst = 1; #1;
    n_cmp++; if ({gpp_gnt, cp_gnt} !== 2'b01) begin n_bad++; $display("FAIL release_gnt got %b want 01", {gpp_gnt, cp_gnt}); end
    @(posedge clk); @(negedge clk); idle_reqs();
    @(posedge clk);
  endtask

  task automatic test_gpp_alone();
    @(negedge clk);
    gpp_req = 1; gpp_we = 1; gpp_addr = 16'h0010; gpp_wdata = 16'hBEEF; #1;
    n_cmp++; if (gpp_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 16'hBEEF) begin n_bad++;
      $display("FAIL gpp_write got gnt=%b we=%b addr=%h wd=%h want 1/1/0010/beef", gpp_gnt, mem_we, mem_addr, mem_wdata); end
    @(posedge clk); #1;
    n_cmp++; if (gpp_rvalid !== 1'b0) begin n_bad++; $display("FAIL write_rvalid got %b want 0", gpp_rvalid); end
    @(negedge clk); gpp_we = 0; #1;
    n_cmp++; if (gpp_gnt !== 1'b1 || mem_we !== 1'b0) begin n_bad++; $display("FAIL gpp_read_gnt got gnt=%b we=%b want 1/0", gpp_gnt, mem_we); end
    @(posedge clk); #1;
    n_cmp++; if (gpp_rvalid !== 1'b1 || gpp_rdata !== 16'hBEEF || cp_rvalid !== 1'b0) begin n_bad++;
      $display("FAIL gpp_read got rv=%b rd=%h cprv=%b want 1/beef/0", gpp_rvalid, gpp_rdata, cp_rvalid); end
    @(negedge clk); idle_reqs(); #1;
    n_cmp++; if (mem_we !== 1'b0 || mem_addr !== 16'h0010 || mem_wdata !== 16'hBEEF) begin n_bad++;
      $display("FAIL idle_hold got we=%b addr=%h wd=%h want 0/0010/beef", mem_we, mem_addr, mem_wdata); end
    @(posedge clk); #1;
    n_cmp++; if (gpp_rvalid !== 1'b0 || gpp_rdata !== 16'hBEEF) begin n_bad++;
      $display("FAIL rvalid_pulse got rv=%b rd=%h want 0/beef", gpp_rvalid, gpp_rdata); end
  endtask

  task automatic test_contention();
    logic [9:0] want_gpp;
    logic [9:0] got_gpp;
    logic [9:0] got_cp;
    want_gpp = 10'b10_0001_0000; // GPP wins in cycles 5 and 10 (index 4, 9)
    got_gpp = '0; got_cp = '0;
    do_reset();
    @(negedge clk);
    gpp_req = 1; gpp_addr = 16'h0030; cp_req = 1; cp_addr = 16'h0020;
    for (int i = 0; i < 10; i++) begin
      #1; got_gpp[i] = gpp_gnt; got_cp[i] = cp_gnt;
      @(posedge clk); @(negedge clk);
    end
    idle_reqs();
    n_cmp++; if (got_gpp !== want_gpp || got_cp !== ~want_gpp) begin n_bad++;
      $display("FAIL contention_seq got gpp=%b cp=%b want gpp=%b cp=%b", got_gpp, got_cp, want_gpp, ~want_gpp); end
    n_cmp++; if (conflict_cnt !== 16'd10) begin n_bad++; $display("FAIL conflict_10 got %0d want 10", conflict_cnt); end
  endtask

  task automatic test_interleave();
    // Seed 0x0003 with 0x1111.
    @(negedge clk); gpp_req = 1; gpp_we = 1; gpp_addr = 16'h0003; gpp_wdata = 16'h1111;
    // CP read and GPP write collide: CP wins and sees old data.
    @(negedge clk); gpp_wdata = 16'h2222; cp_req = 1; cp_we = 0; cp_addr = 16'h0003; #1;
    n_cmp++; if (cp_gnt !== 1'b1 || gpp_gnt !== 1'b0) begin n_bad++; $display("FAIL collide_gnt got cp=%b gpp=%b want 1/0", cp_gnt, gpp_gnt); end
    @(posedge clk); #1;
    n_cmp++; if (cp_rvalid !== 1'b1 || cp_rdata !== 16'h1111) begin n_bad++;
      $display("FAIL cp_read_before got rv=%b rd=%h want 1/1111", cp_rvalid, cp_rdata); end
    @(negedge clk); cp_req = 0;          // GPP write 0x2222 now lands
    @(negedge clk); gpp_wdata = 16'h3333; // GPP writes 0x3333 first
    @(negedge clk); gpp_req = 0; cp_req = 1;
    @(posedge clk); #1;
    n_cmp++; if (cp_rvalid !== 1'b1 || cp_rdata !== 16'h3333) begin n_bad++;
      $display("FAIL cp_read_after got rv=%b rd=%h want 1/3333", cp_rvalid, cp_rdata); end
    @(negedge clk); idle_reqs();
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk); cp_req = 1; cp_we = 0; cp_addr = 16'h0010;
    @(posedge clk); #1; rst = 0; #1;
    n_cmp++; if (cp_rvalid !== 1'b0 || cp_rdata !== 16'h0) begin n_bad++;
      $display("FAIL reset_mid_read got rv=%b rd=%h want 0/0000", cp_rvalid, cp_rdata); end
    @(negedge clk); idle_reqs();
    @(posedge clk); #1;
    n_cmp++; if (cp_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_no_pulse got %b want 0", cp_rvalid); end
    @(negedge clk); rst = 1;
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge clk); gpp_req = 1; cp_req = 1;
    repeat (65534) @(posedge clk);
    #1;
    n_cmp++; if (conflict_cnt !== 16'hFFFE) begin n_bad++; $display("FAIL conflict_fffe got %h want fffe", conflict_cnt); end
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (conflict_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL conflict_sat got %h want ffff", conflict_cnt); end
    @(negedge clk); idle_reqs();
  endtask

  initial begin
    rst = 1; idle_reqs();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    test_reset();
    test_gpp_alone();
    test_contention();
    test_interleave();
    test_reset_mid_read();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
